// File: rtl/jtkicker_gfxrom.sv
// rtl/jtkicker_gfxrom.sv - two-slot (scroll/object) 32-bit graphics ROM cache over a 16-bit SDRAM port
// Each slot holds one 32-bit word; misses are fetched as two SDRAM beats with alternating priority.
module jtkicker_gfxrom #(
  parameter logic [21:0] SCR_OFFSET = 22'h00000,
  parameter logic [21:0] OBJ_OFFSET = 22'h04000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [12:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [13:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [15:0] sdram_din
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, BEAT0, BEAT1} state_t;

  state_t      r_state, w_next;
  logic [12:0] r_scr_tag;
  logic [31:0] r_scr_data;
  logic        r_scr_valid;
  logic [13:0] r_obj_tag;
  logic [31:0] r_obj_data;
  logic        r_obj_valid;
  logic        r_last_obj;
  logic        r_fetch_obj;
  logic [13:0] r_fetch_addr;
  logic [15:0] r_low;
  logic        r_req;
  logic [21:0] r_addr;

  logic        w_scr_pend, w_obj_pend, w_grant_obj;
  logic [21:0] w_scr_sdram, w_obj_sdram;

  assign scr_ok     = r_scr_valid & (r_scr_tag == scr_addr);
  assign obj_ok     = obj_cs & r_obj_valid & (r_obj_tag == obj_addr);
  assign scr_data   = r_scr_data;
  assign obj_data   = r_obj_data;
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;

  assign w_scr_pend  = ~scr_ok;
  assign w_obj_pend  = obj_cs & ~obj_ok;
  // obj only takes priority when scroll had the previous grant
  assign w_grant_obj = w_obj_pend & (~w_scr_pend | ~r_last_obj);
  assign w_scr_sdram = SCR_OFFSET + {8'd0, scr_addr, 1'b0};
  assign w_obj_sdram = OBJ_OFFSET + {7'd0, obj_addr, 1'b0};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_scr_pend | w_obj_pend) w_next = WAIT_ACK;
      WAIT_ACK: if (sdram_ack) w_next = BEAT0;
      BEAT0:    if (sdram_dok) w_next = BEAT1;
      BEAT1:    if (sdram_dok) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scr_tag    <= '0;
      r_scr_data   <= '0;
      r_scr_valid  <= 1'b0;
      r_obj_tag    <= '0;
      r_obj_data   <= '0;
      r_obj_valid  <= 1'b0;
      r_last_obj   <= 1'b1;
      r_fetch_obj  <= 1'b0;
      r_fetch_addr <= '0;
      r_low        <= '0;
      r_req        <= 1'b0;
      r_addr       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_scr_pend | w_obj_pend) begin
          r_fetch_obj  <= w_grant_obj;
          r_last_obj   <= w_grant_obj;
          r_fetch_addr <= w_grant_obj ? obj_addr : {1'b0, scr_addr};
          r_req        <= 1'b1;
          r_addr       <= w_grant_obj ? w_obj_sdram : w_scr_sdram;
        end
        WAIT_ACK: if (sdram_ack) r_req <= 1'b0;
        BEAT0:    if (sdram_dok) r_low <= sdram_din;
        BEAT1: if (sdram_dok) begin
          // stored under the fetch tag even if the client has moved on
          if (r_fetch_obj) begin
            r_obj_data  <= {sdram_din, r_low};
            r_obj_tag   <= r_fetch_addr;
            r_obj_valid <= 1'b1;
          end else begin
            r_scr_data  <= {sdram_din, r_low};
            r_scr_tag   <= r_fetch_addr[12:0];
            r_scr_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_gfxrom.sv
// tb/tb_jtkicker_gfxrom.sv - directed self-checking bench for jtkicker_gfxrom
module tb_jtkicker_gfxrom;
  logic        clk = 1'b0;
  logic        rstn;
  logic [12:0] scr_addr;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [13:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_dok;
  logic [15:0] sdram_din;
  logic [31:0] scr_data2, obj_data2;
  logic        scr_ok2, obj_ok2, sdram_req2;
  logic [21:0] sdram_addr2;
  logic        ack2 = 1'b0, dok2 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtkicker_gfxrom dut (
    .clk(clk), .rstn(rstn),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_dok(sdram_dok), .sdram_din(sdram_din)
  );

  jtkicker_gfxrom #(.SCR_OFFSET(22'h3FFFFF)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .scr_addr(scr_addr), .scr_data(scr_data2), .scr_ok(scr_ok2),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data2), .obj_ok(obj_ok2),
    .sdram_addr(sdram_addr2), .sdram_req(sdram_req2), .sdram_ack(ack2),
    .sdram_dok(dok2), .sdram_din(sdram_din)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!sdram_req && n < 10) begin
      step();
      n++;
    end
    check(tag, {31'd0, sdram_req}, 32'd1);
  endtask

  task automatic serve(input logic [15:0] lo, input logic [15:0] hi);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1;
    sdram_din = lo;
    step();
    sdram_din = hi;
    step();
    sdram_dok = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; scr_addr = 13'h0010; obj_cs = 1'b0; obj_addr = '0;
    sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_din = '0;
    step(); step();
    check("rst_req", {31'd0, sdram_req}, 32'd0);
    check("rst_addr", {10'd0, sdram_addr}, 32'd0);
    check("rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    check("rst_scr_data", scr_data, 32'd0);
    check("rst_obj_data", obj_data, 32'd0);

    // basic scroll miss
    rstn = 1'b1;
    step();
    check("t1_req", {31'd0, sdram_req}, 32'd1);
    check("t1_addr", {10'd0, sdram_addr}, 32'h000020);
    serve(16'hBEEF, 16'hDEAD);
    check("t1_req_drop", {31'd0, sdram_req}, 32'd0);
    check("t1_data", scr_data, 32'hDEADBEEF);
    check("t1_ok", {31'd0, scr_ok}, 32'd1);
    step();
    check("t1_no_refetch", {31'd0, sdram_req}, 32'd0);

    // alternation
    rstn = 1'b0; step();
    rstn = 1'b1; scr_addr = 13'h0; obj_cs = 1'b1; obj_addr = 14'h0001;
    step();
    wait_req("t2_req_scr");
    check("t2_addr_scr", {10'd0, sdram_addr}, 32'h000000);
    serve(16'h1111, 16'h2222);
    check("t2_scr_data", scr_data, 32'h22221111);
    check("t2_obj_ok_low", {31'd0, obj_ok}, 32'd0);
    step();
    check("t2_addr_obj", {10'd0, sdram_addr}, 32'h004002);
    serve(16'h3333, 16'h4444);
    check("t2_obj_data", obj_data, 32'h44443333);
    check("t2_obj_ok", {31'd0, obj_ok}, 32'd1);
    scr_addr = 13'h1; obj_addr = 14'h2;
    step();
    check("t2_addr_scr2", {10'd0, sdram_addr}, 32'h000002);
    serve(16'h5555, 16'h6666);
    check("t2_scr_ok2", {31'd0, scr_ok}, 32'd1);
    scr_addr = 13'h3;
    step();
    check("t2_addr_obj2", {10'd0, sdram_addr}, 32'h004004);
    serve(16'h7777, 16'h8888);
    step();
    check("t2_addr_scr3", {10'd0, sdram_addr}, 32'h000006);
    serve(16'h9999, 16'hAAAA);
    check("t2_scr3_data", scr_data, 32'hAAAA9999);

    // address change mid-fetch
    obj_cs = 1'b0; scr_addr = 13'h5;
    step();
    wait_req("t3_req");
    check("t3_addr", {10'd0, sdram_addr}, 32'h00000A);
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    scr_addr = 13'h6;
    sdram_dok = 1'b1; sdram_din = 16'h0B0B; step();
    sdram_din = 16'h0C0C; step(); sdram_dok = 1'b0;
    check("t3_ok_stays_low", {31'd0, scr_ok}, 32'd0);
    step();
    check("t3_req2", {31'd0, sdram_req}, 32'd1);
    check("t3_addr2", {10'd0, sdram_addr}, 32'h00000C);
    scr_addr = 13'h5; #1;
    check("t3_old_tag_ok", {31'd0, scr_ok}, 32'd1);
    check("t3_old_tag_data", scr_data, 32'h0C0C0B0B);
    scr_addr = 13'h6;
    serve(16'h0D0D, 16'h0E0E);
    check("t3_new_ok", {31'd0, scr_ok}, 32'd1);

    // obj_cs gating
    obj_addr = 14'h0009;
    step(); step(); step();
    check("t4_no_req", {31'd0, sdram_req}, 32'd0);
    check("t4_obj_ok", {31'd0, obj_ok}, 32'd0);
    obj_cs = 1'b1;
    step(); step();
    check("t4_req", {31'd0, sdram_req}, 32'd1);
    check("t4_addr", {10'd0, sdram_addr}, 32'h004012);
    serve(16'h1234, 16'hABCD);
    check("t4_obj_data", obj_data, 32'hABCD1234);
    check("t4_obj_ok2", {31'd0, obj_ok}, 32'd1);

    // reset during BEAT0, stray dok, ack+dok collision
    scr_addr = 13'h7;
    step();
    wait_req("t5_req");
    check("t5_addr", {10'd0, sdram_addr}, 32'h00000E);
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    rstn = 1'b0; #1;
    check("t5_rst_req", {31'd0, sdram_req}, 32'd0);
    check("t5_rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    check("t5_rst_obj_ok", {31'd0, obj_ok}, 32'd0);
    sdram_dok = 1'b1; sdram_din = 16'hFFFF; step(); sdram_dok = 1'b0;
    step();
    check("t5_rst_req2", {31'd0, sdram_req}, 32'd0);
    check("t5_rst_data", scr_data, 32'd0);
    rstn = 1'b1;
    step();
    check("t5_new_req", {31'd0, sdram_req}, 32'd1);
    check("t5_new_addr", {10'd0, sdram_addr}, 32'h00000E);
    sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_din = 16'hAAAA; step();
    sdram_ack = 1'b0; sdram_din = 16'h1234; step();
    sdram_din = 16'h5678; step(); sdram_dok = 1'b0;
    check("t5_collide_data", scr_data, 32'h56781234);
    check("t5_collide_ok", {31'd0, scr_ok}, 32'd1);

    // 22-bit wrap
    obj_cs = 1'b0; scr_addr = 13'h1FFF;
    rstn = 1'b0; step();
    rstn = 1'b1; step();
    check("t6_wrap_addr", {10'd0, sdram_addr2}, 32'h003FFD);
    check("t6_plain_addr", {10'd0, sdram_addr}, 32'h003FFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
